rv32i_mc_controller: RTL
========================

Name: rv32i_mc_controller

Overview:
- Multi-cycle control FSM that sequences the single-issue RV32I datapath.
- Drives the datapath enables: regfile_wren, ir_wren, pc_inc and mem_wren.
- Drives the datapath mux selects: regfile_load_from_mem and ram_raddr_31_20.
- Drives flash boot-copy signals that preload instruction/data memory before execution.
- Decodes the 7-bit opcode from the IR and halts on any unsupported opcode.

Parameters:
- WIDTH, 32, datapath word width; sets flash_addr and instret width.
- RD_LATENCY, 1, memory read latency in cycles (≥1); number of cycles a read address is held before data is captured.
- FLASH_WORDS, 256, number of words copied from flash during boot (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- boot_en  in  1  sampled in IDLE; 1 = run flash copy first, 0 = go straight to fetch.
- flash_valid  in  1  flash_data is valid for the current flash_addr.
- opcode  in  7  instruction[6:0] from the datapath IR.
- regfile_wren  out  1  register file write enable.
- ir_wren  out  1  instruction register load.
- pc_inc  out  1  PC register enable (PC ← PC+4).
- mem_wren  out  1  memory write enable.
- regfile_load_from_mem  out  1  write-back source: 1 = mem_rd_data, 0 = alu_out.
- ram_raddr_31_20  out  1  memory address source: 1 = instruction[31:20], 0 = PC.
- flash_en  out  1  memory writes come from the flash port.
- flash_addr  out  WIDTH  byte address of the current flash word (4 × word index).
- halted  out  1  illegal opcode seen; core stopped.
- booting  out  1  flash copy in progress.
- instret  out  WIDTH  count of retired instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; latency counter=0; word counter=0; instret=0.
  - All outputs 0, flash_addr=0.
- Outputs are Moore (decoded from state and counters only); no input reaches an output combinationally.
- IDLE: boot_en=1 → BOOT; boot_en=0 → FETCH. Exactly one cycle in IDLE.
- BOOT:
  - flash_en=1, booting=1, flash_addr=word_cnt×4.
  - On a cycle with flash_valid=1, the memory write happens, and word_cnt increments on that edge.
  - When the word_cnt==FLASH_WORDS-1 word is accepted → FETCH, with word_cnt cleared.
  - flash_valid=0 stalls indefinitely with flash_addr stable.
- FETCH:
  - ram_raddr_31_20=0 held for RD_LATENCY cycles.
  - On the last cycle, ir_wren=1 and pc_inc=1 together; IR and PC update on the same edge.
  - Next state: DECODE.
- DECODE: one cycle, all enables 0, opcode now valid. Branch on opcode:
  - 7'h33 (OP) or 7'h13 (OP_IMM) → EXEC.
  - 7'h03 (LOAD) → MEM_RD.
  - 7'h23 (STORE) → MEM_WR.
  - Any other value → HALT.
- EXEC: regfile_wren=1, regfile_load_from_mem=0, one cycle → FETCH.
- MEM_RD:
  - ram_raddr_31_20=1 held for RD_LATENCY cycles.
  - On the last cycle, regfile_wren=1 and regfile_load_from_mem=1.
  - Next state: FETCH.
- MEM_WR: ram_raddr_31_20=1 and mem_wren=1 for exactly one cycle → FETCH.
- HALT: halted=1, all enables 0; terminal until reset.
- instret increments by 1 on the exit edge of EXEC, of the final MEM_RD cycle, and of MEM_WR. It wraps modulo 2^WIDTH and does not increment in HALT.
- CPI:
  - ALU = RD_LATENCY+2.
  - LOAD = 2×RD_LATENCY+1.
  - STORE = RD_LATENCY+2.
- Latency counter: counts 0..RD_LATENCY-1, resets to 0 on every state change, and is never observed outside FETCH/MEM_RD.
- Invariants: mem_wren and flash_en are never both 1. regfile_wren, mem_wren and ir_wren are mutually exclusive. pc_inc is only ever high together with ir_wren.
- Reset asserted mid-BOOT or mid-instruction: immediate return to IDLE with all outputs 0. The next run restarts the flash copy from address 0 if boot_en=1.

Test Plan:
- Reset release with boot_en=1, FLASH_WORDS=4, flash_valid toggling 1,0,1,1,1 → flash_addr advances 0,4,4,8,12; booting falls after the 4th accepted word; the first FETCH follows.
- boot_en=0, RD_LATENCY=1, opcode 7'h13 → IDLE,FETCH,DECODE,EXEC,FETCH; ir_wren+pc_inc in cycle 2; regfile_wren in cycle 4; instret=1.
- RD_LATENCY=3, opcode 7'h03 → FETCH 3 cycles, DECODE, MEM_RD 3 cycles with ram_raddr_31_20=1; regfile_wren with load_from_mem=1 only in the third MEM_RD cycle.
- Opcode 7'h23 → exactly one cycle of mem_wren=1 with ram_raddr_31_20=1; regfile_wren stays 0; instret increments.
- Opcode 7'h6F (unsupported) → HALT, halted=1, no further ir_wren or pc_inc for 100 cycles; instret unchanged.
- rst=0 pulsed in the middle of MEM_RD and in the middle of BOOT → outputs go to 0 asynchronously; instret=0; the flash copy restarts at flash_addr=0.

Source files
------------

// File: rtl/rv32i_mc_controller.sv
// Multi-cycle control FSM for the single-issue RV32I datapath: flash boot copy,
// fetch/decode/execute sequencing, illegal-opcode halt and a retired-instruction counter.
module rv32i_mc_controller #(
  parameter int WIDTH       = 32,
  parameter int RD_LATENCY  = 1,
  parameter int FLASH_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_en,
  input  logic             flash_valid,
  input  logic [6:0]       opcode,
  output logic             regfile_wren,
  output logic             ir_wren,
  output logic             pc_inc,
  output logic             mem_wren,
  output logic             regfile_load_from_mem,
  output logic             ram_raddr_31_20,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic             halted,
  output logic             booting,
  output logic [WIDTH-1:0] instret
);

  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LATENCY - 1);
  localparam logic [WIDTH-1:0] WORD_LAST = WIDTH'(FLASH_WORDS - 1);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  // Bit positions inside the registered control-output bundle.
  localparam int O_RFW  = 8;
  localparam int O_IR   = 7;
  localparam int O_PC   = 6;
  localparam int O_MW   = 5;
  localparam int O_LFM  = 4;
  localparam int O_RRA  = 3;
  localparam int O_FEN  = 2;
  localparam int O_HLT  = 1;
  localparam int O_BOOT = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BOOT   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM_RD = 3'd5,
    S_MEM_WR = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [LAT_W-1:0] lat_r, lat_s;
  logic [WIDTH-1:0] word_r, word_s;
  logic [WIDTH-1:0] instret_r, instret_s;
  logic             retire_s;
  logic [8:0]       outs_r, outs_s;
  logic [WIDTH-1:0] flash_addr_r, flash_addr_s;

  // Control outputs as a pure function of a state and whether its latency window ends.
  function automatic logic [8:0] decode_outs(input state_t st, input logic last);
    logic [8:0] o;
    o = 9'b0;
    case (st)
      S_BOOT: begin
        o[O_FEN]  = 1'b1;
        o[O_BOOT] = 1'b1;
      end
      S_FETCH: begin
        if (last) begin
          o[O_IR] = 1'b1;
          o[O_PC] = 1'b1;
        end else begin
          o[O_IR] = 1'b0;
        end
      end
      S_EXEC: o[O_RFW] = 1'b1;
      S_MEM_RD: begin
        o[O_RRA] = 1'b1;
        if (last) begin
          o[O_RFW] = 1'b1;
          o[O_LFM] = 1'b1;
        end else begin
          o[O_RFW] = 1'b0;
        end
      end
      S_MEM_WR: begin
        o[O_RRA] = 1'b1;
        o[O_MW]  = 1'b1;
      end
      S_HALT:  o[O_HLT] = 1'b1;
      default: o = 9'b0;
    endcase
    return o;
  endfunction

  // Next-state, counter and retire logic; latency counter returns to 0 on any state change.
  always_comb begin
    state_s  = state_r;
    lat_s    = {LAT_W{1'b0}};
    word_s   = word_r;
    retire_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (boot_en) state_s = S_BOOT;
        else         state_s = S_FETCH;
      end
      S_BOOT: begin
        if (flash_valid) begin
          if (word_r == WORD_LAST) begin
            state_s = S_FETCH;
            word_s  = {WIDTH{1'b0}};
          end else begin
            word_s = word_r + WIDTH'(1);
          end
        end else begin
          word_s = word_r;
        end
      end
      S_FETCH: begin
        if (lat_r == LAT_LAST) state_s = S_DECODE;
        else                   lat_s   = lat_r + LAT_W'(1);
      end
      S_DECODE: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM: state_s = S_EXEC;
          OPC_LOAD:           state_s = S_MEM_RD;
          OPC_STORE:          state_s = S_MEM_WR;
          default:            state_s = S_HALT;
        endcase
      end
      S_EXEC: begin
        state_s  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEM_RD: begin
        if (lat_r == LAT_LAST) begin
          state_s  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          lat_s = lat_r + LAT_W'(1);
        end
      end
      S_MEM_WR: begin
        state_s  = S_FETCH;
        retire_s = 1'b1;
      end
      S_HALT:  state_s = S_HALT;
      default: state_s = S_HALT;
    endcase

    if (retire_s) instret_s = instret_r + WIDTH'(1);
    else          instret_s = instret_r;

    // Outputs are decoded ahead from the next state so they come straight off flops.
    outs_s       = decode_outs(state_s, lat_s == LAT_LAST);
    flash_addr_s = {word_s[WIDTH-3:0], 2'b00};
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      lat_r        <= {LAT_W{1'b0}};
      word_r       <= {WIDTH{1'b0}};
      instret_r    <= {WIDTH{1'b0}};
      outs_r       <= 9'b0;
      flash_addr_r <= {WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      lat_r        <= lat_s;
      word_r       <= word_s;
      instret_r    <= instret_s;
      outs_r       <= outs_s;
      flash_addr_r <= flash_addr_s;
    end
  end

  assign regfile_wren          = outs_r[O_RFW];
  assign ir_wren               = outs_r[O_IR];
  assign pc_inc                = outs_r[O_PC];
  assign mem_wren              = outs_r[O_MW];
  assign regfile_load_from_mem = outs_r[O_LFM];
  assign ram_raddr_31_20       = outs_r[O_RRA];
  assign flash_en              = outs_r[O_FEN];
  assign halted                = outs_r[O_HLT];
  assign booting               = outs_r[O_BOOT];
  assign flash_addr            = flash_addr_r;
  assign instret               = instret_r;

endmodule
